// File: rtl/alu_param_seq.sv
// Single-cycle registered ALU with status flags and a carry-pattern detector
// that counts matches of a configurable carry sequence.
module alu_param_seq #(
    parameter int unsigned        W       = 8,
    parameter int unsigned        PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    output logic [W-1:0] result,
    output logic         flag_zero,
    output logic         flag_carry,
    output logic         flag_neg,
    output logic         flag_ovf,
    output logic         pat_detect,
    output logic [7:0]   pat_count
);

    localparam int unsigned FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_PASS = 3'b101,
        OP_SHL  = 3'b110,
        OP_RSV  = 3'b111
    } op_e;

    op_e                op_sel;
    logic [W:0]         sum_ext;
    logic [W-1:0]       res_c;
    logic               carry_c;
    logic               ovf_c;
    logic [PAT_LEN-1:0] shreg;
    logic [PAT_LEN-1:0] shreg_nxt;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_nxt;
    logic               match_c;

    assign op_sel = op_e'(op);

    always_comb begin
        sum_ext = '0;
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (op_sel)
            OP_ADD: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                res_c   = sum_ext[W-1:0];
                carry_c = sum_ext[W];
                ovf_c   = (a[W-1] == b[W-1]) && (sum_ext[W-1] != a[W-1]);
            end
            OP_SUB: begin
                // Bit W of the extended difference is the unsigned borrow
                sum_ext = {1'b0, a} - {1'b0, b};
                res_c   = sum_ext[W-1:0];
                carry_c = sum_ext[W];
                ovf_c   = (a[W-1] != b[W-1]) && (sum_ext[W-1] != a[W-1]);
            end
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_XOR:  res_c = a ^ b;
            OP_PASS: res_c = a;
            OP_SHL: begin
                res_c   = {a[W-2:0], 1'b0};
                carry_c = a[W-1];
            end
            OP_RSV:  res_c = '0;
        endcase
    end

    always_comb begin
        shreg_nxt = {shreg[PAT_LEN-2:0], carry_c};
        fill_nxt  = (fill == FILL_MAX) ? fill : fill + 1'b1;
        match_c   = (fill_nxt == FILL_MAX) && (shreg_nxt == PATTERN);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid  <= 1'b0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_neg   <= 1'b0;
            flag_ovf   <= 1'b0;
            pat_detect <= 1'b0;
            pat_count  <= '0;
            shreg      <= '0;
            fill       <= '0;
        end else begin
            out_valid  <= in_valid;
            pat_detect <= in_valid && match_c;
            if (in_valid) begin
                result     <= res_c;
                flag_zero  <= (res_c == '0);
                flag_carry <= carry_c;
                flag_neg   <= res_c[W-1];
                flag_ovf   <= ovf_c;
                shreg      <= shreg_nxt;
                fill       <= fill_nxt;
                if (match_c && (pat_count != 8'hFF))
                    pat_count <= pat_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_param_seq.sv
// Directed bench for alu_param_seq (W=8, PAT_LEN=3, PATTERN=101): vector table
// for the ALU plus hand-written detector and reset sequences.
module tb_alu_param_seq;

    logic       CLK;
    logic       RST;
    logic       in_valid;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic [7:0] result;
    logic       flag_zero;
    logic       flag_carry;
    logic       flag_neg;
    logic       flag_ovf;
    logic       pat_detect;
    logic [7:0] pat_count;

    int n_tests;
    int n_fail;

    alu_param_seq #(
        .W       (8),
        .PAT_LEN (3),
        .PATTERN (3'b101)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_neg   (flag_neg),
        .flag_ovf   (flag_ovf),
        .pat_detect (pat_detect),
        .pat_count  (pat_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // flags packed as {zero, carry, neg, ovf}
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic txn(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb);
        @(negedge CLK);
        in_valid = 1'b1;
        op = o;
        a = xa;
        b = xb;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge CLK);
        in_valid = 1'b0;
        op = 3'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b0;
        #2;
        RST = 1'b1;
    endtask

    task automatic chk_pat(input string nm, input logic det, input logic [7:0] cnt);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_det"}, 32'(pat_detect), 32'(det));
        chk({nm, "_cnt"}, 32'(pat_count), 32'(cnt));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_outs"},
            {8'h0, out_valid, result, flag_zero, flag_carry, flag_neg, flag_ovf, pat_detect, pat_count},
            32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST = 1'b0;
        in_valid = 1'b0;
        op = 3'd0;
        a = 8'd0;
        b = 8'd0;

        vecs[0]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100};
        vecs[1]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011};
        vecs[2]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 4'b0110};
        vecs[3]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[4]  = '{3'b011, 8'hF0, 8'h0C, 8'hFC, 4'b0010};
        vecs[5]  = '{3'b100, 8'hAA, 8'hAA, 8'h00, 4'b1000};
        vecs[6]  = '{3'b101, 8'h5A, 8'h33, 8'h5A, 4'b0000};
        vecs[7]  = '{3'b110, 8'h81, 8'h00, 8'h02, 4'b0100};
        vecs[8]  = '{3'b111, 8'h5A, 8'h33, 8'h00, 4'b1000};
        vecs[9]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001};
        vecs[10] = '{3'b000, 8'h80, 8'h80, 8'h00, 4'b1101};
        vecs[11] = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b1000};
        vecs[12] = '{3'b110, 8'h40, 8'h00, 8'h80, 4'b0010};

        #3;
        chk_all_zero("reset_state");
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 13; i++) begin
            txn(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_res", i), 32'(result), 32'(vecs[i].res));
            chk($sformatf("v%0d_flags", i), 32'({flag_zero, flag_carry, flag_neg, flag_ovf}),
                32'(vecs[i].flags));
        end

        // Idle cycle: out_valid drops, result and flags hold from the last vector
        idle();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_hold", {20'h0, flag_zero, flag_carry, flag_neg, flag_ovf, result}, 32'h0000_0280);

        // Overlapping pattern 1,0,1,0,1 with idles in between
        pulse_reset();
        txn(3'b000, 8'hFF, 8'h01); chk_pat("p1", 1'b0, 8'd0);
        idle();
        txn(3'b000, 8'h01, 8'h01); chk_pat("p2", 1'b0, 8'd0);
        idle();
        idle();
        txn(3'b000, 8'hFF, 8'h01); chk_pat("p3", 1'b1, 8'd1);
        idle();
        chk("p3_pulse_end", 32'({out_valid, pat_detect}), 32'd0);
        chk("p3_cnt_hold", 32'(pat_count), 32'd1);
        txn(3'b000, 8'h01, 8'h01); chk_pat("p4", 1'b0, 8'd1);
        idle();
        txn(3'b000, 8'hFF, 8'h01); chk_pat("p5", 1'b1, 8'd2);

        // Asynchronous reset while out_valid=1, checked before the next edge
        txn(3'b000, 8'hFF, 8'h01);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        RST = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #1;
        RST = 1'b1;

        // Partial match interrupted by reset restarts from empty
        pulse_reset();
        txn(3'b000, 8'hFF, 8'h01); chk_pat("r1", 1'b0, 8'd0);
        txn(3'b000, 8'h01, 8'h01); chk_pat("r2", 1'b0, 8'd0);
        pulse_reset();
        txn(3'b000, 8'hFF, 8'h01); chk_pat("r3", 1'b0, 8'd0);
        txn(3'b000, 8'h01, 8'h01); chk_pat("r4", 1'b0, 8'd0);
        txn(3'b000, 8'hFF, 8'h01); chk_pat("r5", 1'b1, 8'd1);

        // Saturation of pat_count: 1,0 repeated gives a match on every carry=1 from the 3rd txn
        pulse_reset();
        for (int i = 0; i < 260; i++) begin
            txn(3'b000, 8'hFF, 8'h01);
            txn(3'b000, 8'h01, 8'h01);
        end
        chk("sat_cnt", 32'(pat_count), 32'd255);
        txn(3'b000, 8'hFF, 8'h01);
        chk_pat("sat_last", 1'b1, 8'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_param_seq.md
ALU_PARAM_SEQ -- requirements
Module: alu_param_seq

Interface
REQ-001 Parameter W, default 8: operand and result width; legal range 4..32.
REQ-002 Parameter PAT_LEN, default 3: carry-pattern length; legal range 2..8.
REQ-003 Parameter PATTERN, default 3'b101: carry pattern to detect; LSB = newest sample.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operands and opcode valid this cycle.
REQ-007 op  input  3  operation select.
REQ-008 a, b  input  W each  operands, unsigned or two's complement.
REQ-009 out_valid  output  1  result and flags valid this cycle.
REQ-010 result  output  W  registered operation result.
REQ-011 flag_zero, flag_carry, flag_neg, flag_ovf  output  1 each  registered status flags.
REQ-012 pat_detect  output  1  one-cycle pulse on carry-pattern match.
REQ-013 pat_count  output  8  number of matches since reset; saturates at 255.

Function
REQ-014 Latency is exactly 1 cycle: the transaction accepted at edge N (in_valid=1) drives out_valid=1, result and flags after edge N.
REQ-015 With in_valid=0 at an edge: out_valid shall be 0 after it; result, flags and detector state hold.
REQ-016 Opcodes: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 XOR; 101 PASS a; 110 SHL a by 1 (LSB filled with 0); 111 reserved.
REQ-017 Reserved op 111: result=0, flag_zero=1, all other flags=0; the transaction is still accepted.
REQ-018 Arithmetic uses a W+1-bit internal sum; result = low W bits, wrapping modulo 2^W.
REQ-019 flag_carry: ADD = bit W of sum; SUB = borrow (1 when a<b unsigned); SHL = a[W-1]; 0 for all other ops.
REQ-020 flag_ovf: signed overflow for ADD/SUB only; 0 for all other ops.
REQ-021 flag_zero = (result==0); flag_neg = result[W-1]; both registered with the result, never derived combinationally from outputs.
REQ-022 Detector: PAT_LEN-bit shift register of flag_carry values, shifted only on accepted transactions; newest bit enters at LSB.
REQ-023 Fill counter: counts accepted transactions up to PAT_LEN and then saturates; no match is possible until the counter reaches PAT_LEN.
REQ-024 pat_detect=1 in the same cycle as out_valid=1 when the updated shift register equals PATTERN and the fill condition is met; otherwise 0.
REQ-025 Overlapping matches count: with PATTERN 101, carry stream 1,0,1,0,1 produces two pulses.
REQ-026 Idle cycles (in_valid=0) between transactions do not break or reset a partial match.
REQ-027 pat_count increments on each pat_detect pulse and holds at 255.

Reset
REQ-028 RST=0 shall immediately force out_valid, result, all flags, pat_detect and pat_count to 0, independent of CLK.
REQ-029 RST=0 shall clear the shift register and fill counter; a sequence interrupted by reset restarts from empty.
REQ-030 The first edge after RST deasserts behaves as a normal edge; no transaction is lost or duplicated.

Verification (W=8, PAT_LEN=3, PATTERN=101)
REQ-031 Reset pulsed mid-stream while out_valid=1 -> all outputs 0 within the reset pulse, before the next CLK edge.
REQ-032 ADD 0xFF+0x01 -> next cycle: result 0x00, zero=1, carry=1, ovf=0, neg=0, out_valid=1.
REQ-033 ADD 0x7F+0x01 -> result 0x80, neg=1, ovf=1, carry=0; then SUB 0x03-0x05 -> result 0xFE, carry=1, neg=1, ovf=0.
REQ-034 ADDs producing carries 1,0,1,0,1 with idle cycles interleaved -> pat_detect pulses on the 3rd and 5th out_valid; pat_count=2.
REQ-035 Carries 1,0, then RST pulse, then carry 1 -> no pat_detect; pat_count=0.
REQ-036 op=111 with a=0x5A, b=0x33 -> result 0x00, zero=1, other flags 0; SHL 0x81 -> result 0x02, carry=1.
